// File: rtl/simd_instr_encoder.sv
// simd_instr_encoder: packs decoded micro-op fields into 32-bit SIMD
// instruction words, buffers them in a DEPTH-entry FIFO and issues them
// over a valid/ready bus. After a RET is accepted, input is blocked until
// the RET word has been consumed downstream and done has pulsed.
// Optional: define SIMD_ENC_COUNT_EN to add the 16-bit issued_count port
// (saturating count of words popped downstream).
module simd_instr_encoder #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RET_WORD = 32'hD65F03C0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_type,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rn,
  input  logic [4:0]               in_rm,
  input  logic [5:0]               in_shamt,
  input  logic [8:0]               in_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     done,
`ifdef SIMD_ENC_COUNT_EN
  output logic [15:0]              issued_count,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] T_ADD  = 3'b000;
  localparam logic [2:0] T_SUB  = 3'b001;
  localparam logic [2:0] T_MUL  = 3'b010;
  localparam logic [2:0] T_UDIV = 3'b011;
  localparam logic [2:0] T_FADD = 3'b100;
  localparam logic [2:0] T_FSUB = 3'b101;
  localparam logic [2:0] T_LOAD = 3'b110;
  localparam logic [2:0] T_RET  = 3'b111;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  // Pack one micro-op into the decoder's bit layout.
  function automatic logic [31:0] encode(
    input logic [2:0] ty,
    input logic [4:0] rd,
    input logic [4:0] rn,
    input logic [4:0] rm,
    input logic [5:0] sh,
    input logic [8:0] addr
  );
    logic [31:0] w;
    case (ty)
      T_ADD:   w = {11'b10001011000, rm, sh, rn, rd};
      T_SUB:   w = {11'b11001011000, rm, sh, rn, rd};
      T_MUL:   w = {11'b10011011000, rm, sh, rn, rd};
      T_UDIV:  w = {11'b10011010110, rm, sh, rn, rd};
      T_FADD:  w = {11'b00011110011, rm, 6'b001010, rn, rd};
      T_FSUB:  w = {11'b00011110011, rm, 6'b001110, rn, rd};
      T_LOAD:  w = {11'b10101010101, addr, 2'b00, rn, rd};
      default: w = RET_WORD;
    endcase
    return w;
  endfunction

  // Saturating 16-bit increment.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [DEPTH-1:0] tag;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            head_ret;

  assign full      = (fifo_count == FULL_CNT);
  assign empty     = (fifo_count == '0);
  assign in_ready  = (state == RUN) && !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head_ret  = tag[rd_ptr];
  assign out_instr = empty ? 32'h0 : mem[rd_ptr];

  // FIFO storage: encoded word plus RET tag, written at enqueue.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= encode(in_type, in_rd, in_rn, in_rm, in_shamt, in_addr);
      tag[wr_ptr] <= (in_type == T_RET);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Program-end FSM: RUN -> DRAIN on RET accept, DRAIN -> DONE when the
  // tagged RET leaves the FIFO, DONE lasts one cycle with done asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          if (push && (in_type == T_RET)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && head_ret) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef SIMD_ENC_COUNT_EN
  // Words issued downstream, including RET; cleared when done pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_count <= 16'h0;
    end else if (state == DONE) begin
      issued_count <= 16'h0;
    end else if (pop) begin
      issued_count <= sat_inc16(issued_count);
    end
  end
`endif

endmodule

// File: tb/tb_simd_instr_encoder.sv
// Directed testbench for simd_instr_encoder (default DEPTH=4).
module tb_simd_instr_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [4:0]  in_rd;
  logic [4:0]  in_rn;
  logic [4:0]  in_rm;
  logic [5:0]  in_shamt;
  logic [8:0]  in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        done;
  logic [2:0]  fifo_count;
`ifdef SIMD_ENC_COUNT_EN
  logic [15:0] issued_count;
`endif

  int total = 0;
  int bad   = 0;

  simd_instr_encoder #(.DEPTH(4), .RET_WORD(32'hD65F03C0)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_type    (in_type),
    .in_rd      (in_rd),
    .in_rn      (in_rn),
    .in_rm      (in_rm),
    .in_shamt   (in_shamt),
    .in_addr    (in_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .done       (done),
`ifdef SIMD_ENC_COUNT_EN
    .issued_count(issued_count),
`endif
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [5:0] sh, input logic [8:0] addr);
    in_type  = t;
    in_rd    = rd;
    in_rn    = rn;
    in_rm    = rm;
    in_shamt = sh;
    in_addr  = addr;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_encode();
    logic [2:0]  ty  [7];
    logic [4:0]  rd  [7];
    logic [4:0]  rn  [7];
    logic [4:0]  rm  [7];
    logic [5:0]  sh  [7];
    logic [8:0]  ad  [7];
    logic [31:0] exw [7];
    ty[0]=3'b000; rd[0]=3;  rn[0]=1;  rm[0]=2;  sh[0]=0;  ad[0]=9'h0;   exw[0]=32'h8B020023;
    ty[1]=3'b100; rd[1]=0;  rn[1]=1;  rm[1]=2;  sh[1]=63; ad[1]=9'h0;   exw[1]=32'h1E622820;
    ty[2]=3'b101; rd[2]=0;  rn[2]=1;  rm[2]=2;  sh[2]=63; ad[2]=9'h0;   exw[2]=32'h1E623820;
    ty[3]=3'b110; rd[3]=5;  rn[3]=0;  rm[3]=31; sh[3]=63; ad[3]=9'h1FF; exw[3]=32'hAABFF005;
    ty[4]=3'b001; rd[4]=31; rn[4]=31; rm[4]=31; sh[4]=63; ad[4]=9'h0;   exw[4]=32'hCB1FFFFF;
    ty[5]=3'b010; rd[5]=1;  rn[5]=2;  rm[5]=3;  sh[5]=0;  ad[5]=9'h0;   exw[5]=32'h9B030041;
    ty[6]=3'b011; rd[6]=1;  rn[6]=2;  rm[6]=3;  sh[6]=0;  ad[6]=9'h0;   exw[6]=32'h9AC30041;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_op(ty[i], rd[i], rn[i], rm[i], sh[i], ad[i]);
      in_valid = 1'b1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL enc_pre_valid[%0d] got=%b exp=0", i, out_valid); end
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL enc_valid[%0d] got=%b exp=1", i, out_valid); end
      total++; if (out_instr !== exw[i]) begin bad++; $display("FAIL enc_word[%0d] got=%h exp=%h", i, out_instr, exw[i]); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL enc_one_cycle[%0d] got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_op(3'b000, 5'(i), 5'd1, 5'd2, 6'd0, 9'd0);
      in_valid = 1'b1;
      total++; if (in_ready !== (i < 4)) begin bad++; $display("FAIL full_in_ready[%0d] got=%b exp=%b", i, in_ready, (i < 4)); end
      step();
    end
    in_valid = 1'b0;
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
    for (int k = 0; k < 2; k++) begin
      total++; if (out_instr !== 32'h8B020020) begin bad++; $display("FAIL stall_word[%0d] got=%h exp=8b020020", k, out_instr); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", k, out_valid); end
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_instr !== (32'h8B020020 | 32'(i))) begin bad++; $display("FAIL drain_word[%0d] got=%h exp=%h", i, out_instr, 32'h8B020020 | 32'(i)); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 10; i < 12; i++) begin
      set_op(3'b000, 5'(i), 5'd1, 5'd2, 6'd0, 9'd0);
      in_valid = 1'b1;
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_op(3'b000, 5'(12 + k), 5'd1, 5'd2, 6'd0, 9'd0);
      in_valid = 1'b1;
      total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=2", k, fifo_count); end
      total++; if (out_instr !== (32'h8B020020 | 32'(10 + k))) begin bad++; $display("FAIL b2b_word[%0d] got=%h exp=%h", k, out_instr, 32'h8B020020 | 32'(10 + k)); end
      step();
    end
    in_valid = 1'b0;
    for (int k = 3; k < 5; k++) begin
      total++; if (out_instr !== (32'h8B020020 | 32'(10 + k))) begin bad++; $display("FAIL b2b_word[%0d] got=%h exp=%h", k, out_instr, 32'h8B020020 | 32'(10 + k)); end
      step();
    end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL b2b_final_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_ret();
    out_ready = 1'b1;
    set_op(3'b000, 5'd7, 5'd1, 5'd2, 6'd0, 9'd0);
    in_valid = 1'b1;
    step();
    set_op(3'b111, 5'd9, 5'd9, 5'd9, 6'd9, 9'd9);
    total++; if (out_instr !== 32'h8B020027) begin bad++; $display("FAIL ret_add_word got=%h exp=8b020027", out_instr); end
    step();
    set_op(3'b000, 5'd9, 5'd1, 5'd2, 6'd0, 9'd0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ret_drain_ready got=%b exp=0", in_ready); end
    total++; if (out_instr !== 32'hD65F03C0) begin bad++; $display("FAIL ret_word got=%h exp=d65f03c0", out_instr); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ret_done_early got=%b exp=0", done); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ret_done_pulse got=%b exp=1", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ret_done_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ret_done_valid got=%b exp=0", out_valid); end
`ifdef SIMD_ENC_COUNT_EN
    total++; if (issued_count === 16'h0) begin bad++; $display("FAIL ret_issued got=%0d exp=nonzero", issued_count); end
`endif
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ret_done_once got=%b exp=0", done); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ret_resume_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ret_add_blocked got=%b exp=0", out_valid); end
`ifdef SIMD_ENC_COUNT_EN
    total++; if (issued_count !== 16'h0) begin bad++; $display("FAIL ret_issued_clr got=%0d exp=0", issued_count); end
`endif
    step();
    in_valid = 1'b0;
    total++; if (out_instr !== 32'h8B020029) begin bad++; $display("FAIL ret_after_word got=%h exp=8b020029", out_instr); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_op(3'b000, 5'd4, 5'd1, 5'd2, 6'd0, 9'd0);
    in_valid = 1'b1;
    step();
    set_op(3'b111, 5'd0, 5'd0, 5'd0, 6'd0, 9'd0);
    step();
    in_valid = 1'b0;
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL mid_count_pre got=%0d exp=2", fifo_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_drain_ready got=%b exp=0", in_ready); end
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done[%0d] got=%b exp=0", k, done); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready[%0d] got=%b exp=1", k, in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid[%0d] got=%b exp=0", k, out_valid); end
      step();
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_op(3'b000, 5'd0, 5'd0, 5'd0, 6'd0, 9'd0);
    #12;
    test_reset();
    step();
    reset = 1'b0;
    step();
    test_encode();
    test_full();
    test_back_to_back();
    test_ret();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
